regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter: FAIR, default 1, meaning 1 = round-robin between requesters, 0 = fixed priority with core always winning.
REQ-002 Clocking: one clock, clk; reset is rst, synchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 x_req_valid  in  1  request present; x ∈ {c (core), d (debug)}, one port per requester.
REQ-006 x_req_ready  out  1  request accepted this cycle.
REQ-007 x_req_write  in  1  1 = write, 0 = read.
REQ-008 x_req_addrA, x_req_addrB  in  5 each  read addresses.
REQ-009 x_req_addrW  in  5  write address.
REQ-010 x_req_data  in  32  write data.
REQ-011 x_rsp_valid  out  1  read response available.
REQ-012 x_rsp_ready  in  1  response consumed.
REQ-013 x_rsp_dataA, x_rsp_dataB  out  32 each  read data.
REQ-014 rf_regA, rf_regB, rf_regW  out  5 each  register file addresses.
REQ-015 rf_dataIn  out  32  register file write data.
REQ-016 rf_we, rf_re  out  1 each  register file write and read enables; never both 1 in the same cycle.
REQ-017 rf_outA, rf_outB  in  32 each  register file outputs, valid from the cycle after the edge that sampled rf_re.

Function
REQ-018 FSM states: IDLE, RD_WAIT, RSP; owner register records which requester the current read belongs to.
REQ-019 IDLE arbitration, single valid request: grant it.
REQ-020 IDLE arbitration, both valid, FAIR=1: grant the requester not granted last; last_grant updates on every accepted request, read or write.
REQ-021 IDLE arbitration, both valid, FAIR=0: grant core.
REQ-022 x_req_ready is combinational: 1 only for the granted requester, only in IDLE; 0 in RD_WAIT and RSP.
REQ-023 Granted write: same cycle rf_we=1, rf_regW=addrW, rf_dataIn=data, rf_re=0; FSM stays IDLE; no response is generated.
REQ-024 Granted read: same cycle rf_re=1, rf_regA=addrA, rf_regB=addrB; owner latched; next state RD_WAIT.
REQ-025 RD_WAIT lasts exactly one cycle with rf_we=rf_re=0; rf_outA/B are captured into the owner's response registers at its end; next state RSP.
REQ-026 RSP: owner's x_rsp_valid=1 with stable data until x_rsp_ready=1; at that edge x_rsp_valid clears and the FSM returns to IDLE.
REQ-027 The non-owner's x_rsp_valid stays 0 throughout.
REQ-028 Read latency: request accept to x_rsp_valid is 2 cycles; back-to-back read throughput is at most one read per 3 cycles; back-to-back write throughput is one write per cycle.
REQ-029 rf address and data outputs are 0 when no request is granted; rf_we and rf_re are 0 outside grant cycles.
REQ-030 Address 0 is passed through unchanged: reads return what the register file returns (0), and writes are issued (the register file discards them).
REQ-031 Ordering: a write accepted before a read is visible to that read.
REQ-032 A request waiting during RD_WAIT/RSP is held by its requester (valid stable) and arbitrated on return to IDLE.

Reset
REQ-033 On rst: state=IDLE, x_rsp_valid=0, x_rsp_dataA/B=0, last_grant=debug (so core wins the first tie), rf_we=rf_re=0.
REQ-034 rst asserted in RD_WAIT or RSP aborts the read: no response is ever delivered, and nothing is written to the register file.
REQ-035 rst has priority over every other input in the same cycle.

Verification
REQ-036 Core write r5=0x12345678, then core read A=5, B=0 -> c_rsp_valid 2 cycles after accept, dataA=0x12345678, dataB=0.
REQ-037 FAIR=1, both issue reads continuously after reset -> grants alternate c,d,c,d; each response goes only to its requester.
REQ-038 FAIR=0, both valid for 4 transactions -> core granted every time; d_req_ready stays 0.
REQ-039 Response stall: hold c_rsp_ready=0 for 5 cycles -> c_rsp_valid and data stable; no rf_re; d request waits and is granted the cycle after the handshake.
REQ-040 Write r0=0xFFFFFFFF, then read r0 -> dataA=0.
REQ-041 rst pulsed during RD_WAIT -> no rsp_valid afterwards; the next request is serviced normally from IDLE.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-port (core/debug) arbiter in front of a 2-read/1-write register file.
// Writes complete in the grant cycle; reads return through a per-requester response register.
module regfile_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        c_req_valid,
    output logic        c_req_ready,
    input  logic        c_req_write,
    input  logic [4:0]  c_req_addrA,
    input  logic [4:0]  c_req_addrB,
    input  logic [4:0]  c_req_addrW,
    input  logic [31:0] c_req_data,
    output logic        c_rsp_valid,
    input  logic        c_rsp_ready,
    output logic [31:0] c_rsp_dataA,
    output logic [31:0] c_rsp_dataB,

    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_write,
    input  logic [4:0]  d_req_addrA,
    input  logic [4:0]  d_req_addrB,
    input  logic [4:0]  d_req_addrW,
    input  logic [31:0] d_req_data,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_dataA,
    output logic [31:0] d_rsp_dataB,

    output logic [4:0]  rf_regA,
    output logic [4:0]  rf_regB,
    output logic [4:0]  rf_regW,
    output logic [31:0] rf_dataIn,
    output logic        rf_we,
    output logic        rf_re,
    input  logic [31:0] rf_outA,
    input  logic [31:0] rf_outB
);

    // state   | meaning
    // IDLE    | arbitrate; writes retire here, reads launch rf_re
    // RD_WAIT | register file producing read data for owner
    // RSP     | owner's response held until its rsp_ready
    typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

    state_t state;
    logic   owner;       // 1 = debug
    logic   last_grant;  // 1 = debug
    logic   gnt_c, gnt_d;
    logic   sel_write;

    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (!rst && state == IDLE) begin
            if (c_req_valid && d_req_valid) begin
                if (FAIR && !last_grant) gnt_d = 1'b1;
                else                     gnt_c = 1'b1;
            end else begin
                gnt_c = c_req_valid;
                gnt_d = d_req_valid;
            end
        end
    end

    assign c_req_ready = gnt_c;
    assign d_req_ready = gnt_d;

    always_comb begin
        sel_write = 1'b0;
        rf_we     = 1'b0;
        rf_re     = 1'b0;
        rf_regA   = 5'd0;
        rf_regB   = 5'd0;
        rf_regW   = 5'd0;
        rf_dataIn = 32'd0;
        if (gnt_c || gnt_d) begin
            sel_write = gnt_c ? c_req_write : d_req_write;
            if (sel_write) begin
                rf_we     = 1'b1;
                rf_regW   = gnt_c ? c_req_addrW : d_req_addrW;
                rf_dataIn = gnt_c ? c_req_data  : d_req_data;
            end else begin
                rf_re   = 1'b1;
                rf_regA = gnt_c ? c_req_addrA : d_req_addrA;
                rf_regB = gnt_c ? c_req_addrB : d_req_addrB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            c_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            c_rsp_dataA <= 32'd0;
            c_rsp_dataB <= 32'd0;
            d_rsp_dataA <= 32'd0;
            d_rsp_dataB <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_c || gnt_d) begin
                        last_grant <= gnt_d;
                        if (!sel_write) begin
                            owner <= gnt_d;
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (owner) begin
                        d_rsp_dataA <= rf_outA;
                        d_rsp_dataB <= rf_outB;
                        d_rsp_valid <= 1'b1;
                    end else begin
                        c_rsp_dataA <= rf_outA;
                        c_rsp_dataB <= rf_outB;
                        c_rsp_valid <= 1'b1;
                    end
                    state <= RSP;
                end
                RSP: begin
                    if (owner ? d_rsp_ready : c_rsp_ready) begin
                        c_rsp_valid <= 1'b0;
                        d_rsp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: scoreboard of expected read responses,
// a behavioural register file, and a FAIR=0 instance sharing the request inputs.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req_valid = 0, c_req_write = 0, c_rsp_ready = 1;
    logic [4:0]  c_req_addrA = 0, c_req_addrB = 0, c_req_addrW = 0;
    logic [31:0] c_req_data = 0;
    logic        d_req_valid = 0, d_req_write = 0, d_rsp_ready = 1;
    logic [4:0]  d_req_addrA = 0, d_req_addrB = 0, d_req_addrW = 0;
    logic [31:0] d_req_data = 0;

    logic        c_req_ready, c_rsp_valid, d_req_ready, d_rsp_valid;
    logic [31:0] c_rsp_dataA, c_rsp_dataB, d_rsp_dataA, d_rsp_dataB;
    logic [4:0]  rf_regA, rf_regB, rf_regW;
    logic [31:0] rf_dataIn, rf_outA, rf_outB;
    logic        rf_we, rf_re;

    logic        c_req_ready0, c_rsp_valid0, d_req_ready0, d_rsp_valid0;
    logic [31:0] c_rsp_dataA0, c_rsp_dataB0, d_rsp_dataA0, d_rsp_dataB0;
    logic [4:0]  rf_regA0, rf_regB0, rf_regW0;
    logic [31:0] rf_dataIn0;
    logic        rf_we0, rf_re0;
    logic [31:0] zero32 = 32'd0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          who;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    exp_t sb[$];

    logic [31:0] regs [32];

    always #5 clk = ~clk;

    regfile_arbiter #(.FAIR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_write(c_req_write),
        .c_req_addrA(c_req_addrA), .c_req_addrB(c_req_addrB), .c_req_addrW(c_req_addrW),
        .c_req_data(c_req_data), .c_rsp_valid(c_rsp_valid), .c_rsp_ready(c_rsp_ready),
        .c_rsp_dataA(c_rsp_dataA), .c_rsp_dataB(c_rsp_dataB),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
        .d_req_addrA(d_req_addrA), .d_req_addrB(d_req_addrB), .d_req_addrW(d_req_addrW),
        .d_req_data(d_req_data), .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_dataA(d_rsp_dataA), .d_rsp_dataB(d_rsp_dataB),
        .rf_regA(rf_regA), .rf_regB(rf_regB), .rf_regW(rf_regW), .rf_dataIn(rf_dataIn),
        .rf_we(rf_we), .rf_re(rf_re), .rf_outA(rf_outA), .rf_outB(rf_outB)
    );

    regfile_arbiter #(.FAIR(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready0), .c_req_write(c_req_write),
        .c_req_addrA(c_req_addrA), .c_req_addrB(c_req_addrB), .c_req_addrW(c_req_addrW),
        .c_req_data(c_req_data), .c_rsp_valid(c_rsp_valid0), .c_rsp_ready(c_rsp_ready),
        .c_rsp_dataA(c_rsp_dataA0), .c_rsp_dataB(c_rsp_dataB0),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready0), .d_req_write(d_req_write),
        .d_req_addrA(d_req_addrA), .d_req_addrB(d_req_addrB), .d_req_addrW(d_req_addrW),
        .d_req_data(d_req_data), .d_rsp_valid(d_rsp_valid0), .d_rsp_ready(d_rsp_ready),
        .d_rsp_dataA(d_rsp_dataA0), .d_rsp_dataB(d_rsp_dataB0),
        .rf_regA(rf_regA0), .rf_regB(rf_regB0), .rf_regW(rf_regW0), .rf_dataIn(rf_dataIn0),
        .rf_we(rf_we0), .rf_re(rf_re0), .rf_outA(zero32), .rf_outB(zero32)
    );

    // Behavioural register file: r0 reads as 0, read data registered on rf_re.
    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rf_outA = 32'd0;
        rf_outB = 32'd0;
    end

    always @(posedge clk) begin
        if (rf_re) begin
            rf_outA <= (rf_regA == 5'd0) ? 32'd0 : regs[rf_regA];
            rf_outB <= (rf_regB == 5'd0) ? 32'd0 : regs[rf_regB];
        end
        if (rf_we && rf_regW != 5'd0) regs[rf_regW] <= rf_dataIn;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_chk(input bit who, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: got response on port %0d expected none at %0t", who, $time);
        end else begin
            e = sb.pop_front();
            chk("rsp_owner", {31'd0, who}, {31'd0, e.who});
            chk("rsp_dataA", a, e.a);
            chk("rsp_dataB", b, e.b);
        end
    endtask

    // Response monitor, decoupled from stimulus.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rsp_exclusive", {31'd0, c_rsp_valid & d_rsp_valid}, 32'd0);
            chk("we_re_exclusive", {31'd0, rf_we & rf_re}, 32'd0);
            if (c_rsp_valid && c_rsp_ready) pop_chk(1'b0, c_rsp_dataA, c_rsp_dataB);
            if (d_rsp_valid && d_rsp_ready) pop_chk(1'b1, d_rsp_dataA, d_rsp_dataB);
        end
    end

    function automatic logic rdy(input bit who);
        return who ? d_req_ready : c_req_ready;
    endfunction

    function automatic logic rsp_v(input bit who);
        return who ? d_rsp_valid : c_rsp_valid;
    endfunction

    task automatic drive(input bit who, input logic v, input logic wr, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] w, input logic [31:0] dt);
        if (!who) begin
            c_req_valid = v; c_req_write = wr; c_req_addrA = a;
            c_req_addrB = b; c_req_addrW = w;  c_req_data = dt;
        end else begin
            d_req_valid = v; d_req_write = wr; d_req_addrA = a;
            d_req_addrB = b; d_req_addrW = w;  d_req_data = dt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-requester transaction; reads also check the 2-cycle response latency.
    task automatic xact(input bit who, input logic wr, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] w, input logic [31:0] dt,
                        input logic [31:0] ea, input logic [31:0] eb);
        int n;
        exp_t e;
        drive(who, 1'b1, wr, a, b, w, dt);
        n = 0;
        @(negedge clk);
        while (!rdy(who) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", {31'd0, rdy(who)}, 32'd1);
        if (wr) begin
            chk("rf_we", {31'd0, rf_we}, 32'd1);
            chk("rf_re_on_write", {31'd0, rf_re}, 32'd0);
            chk("rf_regW", {27'd0, rf_regW}, {27'd0, w});
            chk("rf_dataIn", rf_dataIn, dt);
        end else begin
            chk("rf_re", {31'd0, rf_re}, 32'd1);
            chk("rf_we_on_read", {31'd0, rf_we}, 32'd0);
            chk("rf_regA", {27'd0, rf_regA}, {27'd0, a});
            chk("rf_regB", {27'd0, rf_regB}, {27'd0, b});
            e.who = who; e.a = ea; e.b = eb;
            sb.push_back(e);
        end
        tick();
        drive(who, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        if (!wr) begin
            @(negedge clk);
            chk("rd_wait_valid", {31'd0, rsp_v(who)}, 32'd0);
            chk("rd_wait_re", {31'd0, rf_re}, 32'd0);
            chk("rd_wait_we", {31'd0, rf_we}, 32'd0);
            chk("idle_rf_regA", {27'd0, rf_regA}, 32'd0);
            @(negedge clk);
            chk("rsp_latency", {31'd0, rsp_v(who)}, 32'd1);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;

        // Reset wins over a valid write request.
        drive(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 32'hDEAD_BEEF);
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready", {31'd0, c_req_ready}, 32'd0);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_c_rsp_valid", {31'd0, c_rsp_valid}, 32'd0);
        chk("reset_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        chk("reset_c_dataA", c_rsp_dataA, 32'd0);
        chk("reset_d_dataB", d_rsp_dataB, 32'd0);
        chk("reset_rf_re", {31'd0, rf_re}, 32'd0);
        chk("reset_rf_regW", {27'd0, rf_regW}, 32'd0);
        tick();

        // Write then read back; address 0 passes through.
        xact(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h1234_5678, 32'd0, 32'd0);
        xact(1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0, 32'h1234_5678, 32'd0);
        xact(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
        xact(1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 32'd0, 32'd0, 32'h1234_5678);
        xact(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 32'hA5A5_0001, 32'd0, 32'd0);
        xact(1'b1, 1'b0, 5'd7, 5'd5, 5'd0, 32'd0, 32'hA5A5_0001, 32'h1234_5678);

        // Response stall with a debug read waiting; last grant was debug so core wins.
        c_rsp_ready = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd7, 5'd0, 32'd0);
        @(negedge clk);
        chk("stall_c_grant", {31'd0, c_req_ready}, 32'd1);
        chk("stall_d_wait", {31'd0, d_req_ready}, 32'd0);
        e.who = 1'b0; e.a = 32'hA5A5_0001; e.b = 32'd0;
        sb.push_back(e);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        chk("stall_rdwait_d", {31'd0, d_req_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, c_rsp_valid}, 32'd1);
            chk("stall_dataA", c_rsp_dataA, 32'hA5A5_0001);
            chk("stall_dataB", c_rsp_dataB, 32'd0);
            chk("stall_no_re", {31'd0, rf_re}, 32'd0);
            chk("stall_d_ready", {31'd0, d_req_ready}, 32'd0);
        end
        tick();
        c_rsp_ready = 1'b1;
        @(negedge clk);
        chk("hs_d_ready", {31'd0, d_req_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("after_hs_d_grant", {31'd0, d_req_ready}, 32'd1);
        chk("after_hs_rf_re", {31'd0, rf_re}, 32'd1);
        e.who = 1'b1; e.a = 32'h1234_5678; e.b = 32'hA5A5_0001;
        sb.push_back(e);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        chk("d_rd_wait", {31'd0, d_rsp_valid}, 32'd0);
        @(negedge clk);
        chk("d_rsp_latency", {31'd0, d_rsp_valid}, 32'd1);
        tick();

        // Round robin with both requesters reading continuously.
        drive(1'b0, 1'b1, 1'b0, 5'd5, 5'd7, 5'd0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd5, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            @(negedge clk);
            while (!(c_req_ready || d_req_ready) && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("rr_grant_is_debug", {31'd0, d_req_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_grant_is_core", {31'd0, c_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            e.who = d_req_ready;
            e.a = d_req_ready ? 32'hA5A5_0001 : 32'h1234_5678;
            e.b = d_req_ready ? 32'h1234_5678 : 32'hA5A5_0001;
            sb.push_back(e);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (4) tick();

        // Back-to-back writes from both: FAIR=0 always core, FAIR=1 alternates.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd10, 32'h100 + i);
            drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd11, 32'h200 + i);
            @(negedge clk);
            chk("fixed_c_ready", {31'd0, c_req_ready0}, 32'd1);
            chk("fixed_d_ready", {31'd0, d_req_ready0}, 32'd0);
            chk("fixed_regW", {27'd0, rf_regW0}, 32'd10);
            chk("fair_wr_core", {31'd0, c_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("fair_wr_we", {31'd0, rf_we}, 32'd1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        xact(1'b0, 1'b0, 5'd10, 5'd11, 5'd0, 32'd0, 32'h102, 32'h203);

        // Reset during RD_WAIT aborts the read (no scoreboard entry).
        drive(1'b0, 1'b1, 1'b0, 5'd5, 5'd7, 5'd0, 32'd0);
        @(negedge clk);
        chk("abort_accept", {31'd0, c_req_ready}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_we", {31'd0, rf_we}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, c_rsp_valid}, 32'd0);
            chk("abort_dataA", c_rsp_dataA, 32'd0);
        end
        tick();
        xact(1'b0, 1'b0, 5'd7, 5'd5, 5'd0, 32'd0, 32'hA5A5_0001, 32'h1234_5678);

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
